serial_adder_scheduler: RTL and testbench
=========================================

# serial_adder_scheduler

Sequencing and sharing controller for the bit-serial accumulating adder (`adder`: A, B, clk, rst, sum, cr_out, done). Accepts add requests from NREQ requesters over valid/ready handshakes, grants them round-robin, loads operands into the single serial adder, starts it, waits for its `done` and returns sum, carry and requester ID through one buffered response port. Sits between the requester clients and one `adder` instance.

## Interface
- NREQ, 4: number of requesters (2..8).
- WIDTH, 8: operand/sum width; must match the adder.
- TIMEOUT, 12: max RUN cycles before abort (only with SCHED_TIMEOUT_EN).
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NREQ  request pending, one bit per requester.
- req_ready  out  NREQ  one-hot accept pulse; transfer when valid&&ready.
- req_a  in  NREQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand B, same packing.
- add_clr  out  1  to adder rst; high = adder cleared/held.
- add_a  out  WIDTH  to adder A.
- add_b  out  WIDTH  to adder B.
- add_sum  in  WIDTH  from adder sum.
- add_carry  in  1  from adder cr_out.
- add_done  in  1  from adder done.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts response.
- resp_id  out  clog2(NREQ)  requester index of the response.
- resp_sum  out  WIDTH  captured sum.
- resp_carry  out  1  captured carry.
- resp_err  out  1  adder timed out; sum/carry forced 0.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM: IDLE -> LOAD -> RUN -> RESP -> IDLE.
- IDLE: add_clr=1. If any req_valid: rr_arbiter picks lowest index at or after pointer `ptr` (wrapping); req_ready[g]=1 for that cycle only; req_a/req_b slice g and g captured into op regs/id reg; go LOAD. No valid: stay.
- LOAD (1 cycle): add_clr=1, add_a/add_b driven from op regs (held constant through RUN). ptr <= (g+1) mod NREQ.
- RUN: add_clr=0. add_done=1 -> capture add_sum/add_carry into resp regs, resp_err=0, go RESP.
- RESP: resp_valid=1, outputs stable; resp_valid&&resp_ready -> IDLE, add_clr=1. resp_ready low -> hold indefinitely; no grants while in LOAD/RUN/RESP (req_ready all 0).
- add_done ignored outside RUN (adder held cleared).
- req_valid dropping after grant has no effect; operands already captured.
- Simultaneous all requesters valid: grants 0,1,2,...,NREQ-1,0 in order.
- rst mid-operation: FSM to IDLE, in-flight request and pending response discarded, ptr=0.
- Reset values: req_ready=0, add_clr=1, add_a=0, add_b=0, resp_valid=0, resp_id=0, resp_sum=0, resp_carry=0, resp_err=0, busy=0, ptr=0.

## Timing
- Grant cycle T (req_ready high); LOAD at T+1; RUN from T+2 (add_clr low).
- Response: resp_valid rises the cycle after add_done is sampled high in RUN.
- Earliest next grant: cycle after resp handshake.
- Throughput: one add per (adder latency + 4) cycles with resp_ready tied high.
- req_ready is combinational from req_valid and ptr in IDLE; all other outputs registered.

## Configuration
- SCHED_TIMEOUT_EN defined: 8-bit cycle counter cleared on LOAD, increments in RUN; reaching TIMEOUT without add_done -> RESP with resp_err=1, resp_sum=0, resp_carry=0; add_clr reasserted.
- Undefined: no counter; RUN waits for add_done indefinitely; resp_err tied 0.

## Structure
- Package serial_sched_pkg: state enum (IDLE, LOAD, RUN, RESP), default NREQ/WIDTH/TIMEOUT constants, index-width function.
- Sub-module rr_arbiter: req vector + ptr in, one-hot grant + encoded index out, purely combinational.
- Top instantiates rr_arbiter; adder instantiated only in the bench.

## Test plan
- Single request: req_valid=4'b0010, A=8'h3C, B=8'h55 -> req_ready=4'b0010 one cycle; resp_id=1, resp_sum=8'h91, resp_carry=0.
- Overflow: requester 0, A=8'hFF, B=8'h01 -> resp_sum=8'h00, resp_carry=1.
- Fairness: all four valid continuously, resp_ready=1 -> resp_id sequence 0,1,2,3,0; no requester granted twice before others.
- Backpressure: resp_ready=0 for 20 cycles after resp_valid -> response stable, busy=1, req_ready all 0; releasing resp_ready -> next grant the following cycle.
- Reset mid-RUN: rst pulsed 3 cycles after LOAD -> all outputs at reset values, no resp_valid, next grant to requester 0.
- Timeout (SCHED_TIMEOUT_EN): add_done held 0 -> resp_valid with resp_err=1, resp_sum=0 after TIMEOUT=12 RUN cycles.

Source files
------------

// File: rtl/serial_adder_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module : serial_sched_pkg
//  Shared definitions for the serial adder scheduler: FSM state encoding,
//  default configuration constants and an index-width helper.
//  Revision: 1.0 - initial release
// ============================================================================
package serial_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } state_e;

  localparam int DEF_NREQ    = 4;
  localparam int DEF_WIDTH   = 8;
  localparam int DEF_TIMEOUT = 12;

  // Width of a requester index; never below one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_adder_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module : rr_arbiter
//  Purely combinational round-robin picker: selects the lowest-indexed
//  active request at or after the priority pointer, wrapping around.
//  Ports : req_i  - request vector
//          ptr_i  - index with highest priority
//          gnt_o  - one-hot grant
//          idx_o  - encoded grant index
//          any_o  - at least one request active
//  Revision: 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  int            j;
  logic [IW-1:0] jj;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    jj    = '0;
    // Walk from the pointer upward, wrapping; the first hit wins.
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr_i) + k;
      if (j >= NREQ) j = j - NREQ;
      jj = IW'(j);
      if (!any_o && req_i[jj]) begin
        any_o     = 1'b1;
        gnt_o[jj] = 1'b1;
        idx_o     = jj;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/serial_adder_scheduler.sv
`default_nettype none
// ============================================================================
//  Module : serial_adder_scheduler
//  Shares one bit-serial accumulating adder among NREQ requesters. Requests
//  are granted round-robin, operands are loaded into the adder, the adder is
//  released from clear until it reports done, and the result is returned on
//  a single buffered response port.
//  Ports : req_valid/req_ready/req_a/req_b   - requester side (packed)
//          add_clr/add_a/add_b               - drive the adder
//          add_sum/add_carry/add_done        - adder results
//          resp_valid/resp_ready/resp_id/resp_sum/resp_carry/resp_err
//                                            - response port
//          busy                              - not idle
//  Build option: SCHED_TIMEOUT_EN adds an 8-bit RUN cycle watchdog that
//          aborts after TIMEOUT cycles with resp_err set.
//  Revision: 1.0 - initial release
// ============================================================================
module serial_adder_scheduler
  import serial_sched_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH
`ifdef SCHED_TIMEOUT_EN
  , parameter int TIMEOUT = DEF_TIMEOUT
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic                    add_clr,
  output logic [WIDTH-1:0]        add_a,
  output logic [WIDTH-1:0]        add_b,
  input  logic [WIDTH-1:0]        add_sum,
  input  logic                    add_carry,
  input  logic                    add_done,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [idx_w(NREQ)-1:0]  resp_id,
  output logic [WIDTH-1:0]        resp_sum,
  output logic                    resp_carry,
  output logic                    resp_err,
  output logic                    busy
);

  localparam int IW = idx_w(NREQ);

  state_e            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     id_q, id_d;
  logic [WIDTH-1:0]  op_a_q, op_a_d;
  logic [WIDTH-1:0]  op_b_q, op_b_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              carry_q, carry_d;

  logic [NREQ-1:0]   arb_gnt;
  logic [IW-1:0]     arb_idx;
  logic              arb_any;

`ifdef SCHED_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
`endif

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
`ifdef SCHED_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          id_d    = arb_idx;
          op_a_d  = req_a[arb_idx*WIDTH +: WIDTH];
          op_b_d  = req_b[arb_idx*WIDTH +: WIDTH];
          state_d = LOAD;
        end
      end
      LOAD: begin
        // Priority moves just past the requester now being served.
        ptr_d   = (id_q == IW'(NREQ - 1)) ? '0 : id_q + 1'b1;
`ifdef SCHED_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = RUN;
      end
      RUN: begin
`ifdef SCHED_TIMEOUT_EN
        cnt_d = cnt_q + 8'd1;
`endif
        if (add_done) begin
          sum_d   = add_sum;
          carry_d = add_carry;
`ifdef SCHED_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = RESP;
        end
`ifdef SCHED_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          sum_d   = '0;
          carry_d = 1'b0;
          err_d   = 1'b1;
          state_d = RESP;
        end
`endif
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
`ifdef SCHED_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  // The adder only runs in RUN; everywhere else it is held cleared.
  assign req_ready  = (state_q == IDLE) ? arb_gnt : '0;
  assign add_clr    = (state_q != RUN);
  assign add_a      = op_a_q;
  assign add_b      = op_b_q;
  assign resp_valid = (state_q == RESP);
  assign resp_id    = id_q;
  assign resp_sum   = sum_q;
  assign resp_carry = carry_q;
  assign busy       = (state_q != IDLE);
`ifdef SCHED_TIMEOUT_EN
  assign resp_err   = err_q;
`else
  assign resp_err   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_scheduler.sv
`default_nettype none
// ============================================================================
//  Module : tb_serial_adder_scheduler
//  Directed + randomized bench for serial_adder_scheduler with a behavioural
//  serial adder and a round-robin / arithmetic reference model.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_serial_adder_scheduler;

  localparam int NREQ    = 4;
  localparam int WIDTH   = 8;
  localparam int IW      = 2;
  localparam int TIMEOUT = 12;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic                  add_clr;
  logic [WIDTH-1:0]      add_a, add_b, add_sum;
  logic                  add_carry, add_done;
  logic                  resp_valid, resp_ready;
  logic [IW-1:0]         resp_id;
  logic [WIDTH-1:0]      resp_sum;
  logic                  resp_carry, resp_err, busy;

  int checks   = 0;
  int failures = 0;
  int ptr_m    = 0;
  bit stall    = 1'b0;

  logic [WIDTH-1:0] op_a [NREQ];
  logic [WIDTH-1:0] op_b [NREQ];

  always #5 clk = ~clk;

  serial_adder_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .add_clr    (add_clr),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_sum    (add_sum),
    .add_carry  (add_carry),
    .add_done   (add_done),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_sum   (resp_sum),
    .resp_carry (resp_carry),
    .resp_err   (resp_err),
    .busy       (busy)
  );

  // Behavioural adder: WIDTH cycles out of clear, then done with A+B.
  int a_cnt;
  always @(posedge clk) begin
    if (add_clr) begin
      a_cnt     <= 0;
      add_done  <= 1'b0;
      add_sum   <= '0;
      add_carry <= 1'b0;
    end else if (!stall && !add_done) begin
      if (a_cnt == WIDTH - 1) begin
        {add_carry, add_sum} <= 9'(add_a) + 9'(add_b);
        add_done <= 1'b1;
      end
      a_cnt <= a_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_pick(input logic [NREQ-1:0] m);
    for (int k = 0; k < NREQ; k++)
      if (m[(ptr_m + k) % NREQ]) return (ptr_m + k) % NREQ;
    return 0;
  endfunction

  task automatic set_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*WIDTH +: WIDTH] = op_a[i];
      req_b[i*WIDTH +: WIDTH] = op_b[i];
    end
  endtask

  task automatic chk_reset_vals(input string p);
    chk({p, "_req_ready"},  req_ready, 0);
    chk({p, "_add_clr"},    add_clr, 1);
    chk({p, "_add_a"},      add_a, 0);
    chk({p, "_add_b"},      add_b, 0);
    chk({p, "_resp_valid"}, resp_valid, 0);
    chk({p, "_resp_id"},    resp_id, 0);
    chk({p, "_resp_sum"},   resp_sum, 0);
    chk({p, "_resp_carry"}, resp_carry, 0);
    chk({p, "_resp_err"},   resp_err, 0);
    chk({p, "_busy"},       busy, 0);
  endtask

  // One full transaction. Entered and left at a negedge; on exit the DUT is
  // in RESP with resp_ready high, so the handshake occurs at the next edge.
  task automatic txn(input logic [NREQ-1:0] mask, input bit keep, input int hold, input bit tmo);
    int g, runc, bad;
    bit seen, prev_done;
    logic [8:0] s;
    @(posedge clk); #1;
    req_valid = mask;
    if (hold > 0) resp_ready = 1'b0;
    g = model_pick(mask);
    s = tmo ? 9'd0 : 9'(op_a[g]) + 9'(op_b[g]);
    @(negedge clk);
    chk("grant", req_ready, 32'(1) << g);
    chk("idle_busy", busy, 0);
    chk("idle_resp_valid", resp_valid, 0);
    ptr_m = (g + 1) % NREQ;
    @(posedge clk); #1;
    if (!keep) req_valid[g] = 1'b0;
    @(negedge clk);
    chk("load_ready", req_ready, 0);
    chk("load_clr", add_clr, 1);
    chk("load_busy", busy, 1);
    chk("load_a", add_a, op_a[g]);
    chk("load_b", add_b, op_b[g]);
    seen = 1'b0; prev_done = 1'b0; runc = 0; bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (resp_valid) begin seen = 1'b1; break; end
      if (!add_clr) runc++;
      if (req_ready !== '0) bad++;
      prev_done = add_done;
    end
    chk("resp_seen", seen, 1);
    if (seen) begin
      chk("run_ready_zero", bad, 0);
      chk("resp_id", resp_id, g);
      chk("resp_sum", resp_sum, s[WIDTH-1:0]);
      chk("resp_carry", resp_carry, s[WIDTH]);
      chk("resp_err", resp_err, tmo);
      chk("run_cycles", runc, tmo ? TIMEOUT : WIDTH + 1);
      if (!tmo) chk("resp_after_done", prev_done, 1);
      if (hold > 0) begin
        bad = 0;
        for (int i = 0; i < hold; i++) begin
          @(negedge clk);
          if (resp_valid !== 1'b1 || resp_id !== IW'(g) || resp_sum !== s[WIDTH-1:0] ||
              resp_carry !== s[WIDTH] || busy !== 1'b1 || req_ready !== '0) bad++;
        end
        chk("hold_stable", bad, 0);
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(negedge clk);
        chk("hold_release_valid", resp_valid, 1);
      end
    end
  endtask

  initial begin
    int cnt;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin op_a[i] = '0; op_b[i] = '0; end
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);

    // Single request from requester 1; valid dropped after the grant.
    op_a[1] = 8'h3C; op_b[1] = 8'h55; set_ops();
    txn(4'b0010, 1'b0, 0, 1'b0);

    // Overflow on requester 0 (pointer wraps past 3).
    op_a[0] = 8'hFF; op_b[0] = 8'h01; set_ops();
    txn(4'b0001, 1'b0, 0, 1'b0);

    // Random masks and operands.
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        op_a[i] = WIDTH'($urandom);
        op_b[i] = WIDTH'($urandom);
      end
      set_ops();
      txn(NREQ'($urandom_range(1, 15)), 1'b0, 0, 1'b0);
    end

    // Backpressure: response held 20 cycles, then an immediate next grant.
    txn(4'b0101, 1'b1, 20, 1'b0);
    txn(4'b0101, 1'b1, 0, 1'b0);

    // Reset three cycles after LOAD.
    @(posedge clk); #1;
    req_valid = 4'b0100;
    @(negedge clk);
    chk("rst_pre_grant", req_ready, 32'(1) << model_pick(4'b0100));
    @(posedge clk); #1;
    req_valid = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk_reset_vals("midrun");
    @(posedge clk); #1 rst = 1'b0;
    ptr_m = 0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || busy !== 1'b0) cnt++;
    end
    chk("post_rst_quiet", cnt, 0);

    // Fairness: all valid continuously, grants must rotate from 0.
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = WIDTH'(8'h10 * (i + 1));
      op_b[i] = WIDTH'(8'hE7 - i);
    end
    set_ops();
    for (int n = 0; n < 5; n++) txn(4'b1111, 1'b1, 0, 1'b0);
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);

`ifdef SCHED_TIMEOUT_EN
    // Adder never finishes: watchdog must abort with an error response.
    stall = 1'b1;
    txn(4'b1000, 1'b0, 0, 1'b1);
    @(posedge clk); #1 stall = 1'b0;
    @(negedge clk);
    txn(4'b1000, 1'b0, 0, 1'b0);
`endif

    @(posedge clk); #1 req_valid = '0;
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
